// File: rtl/audio_frame_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : audio_pkg
// Description : Shared constants and types for the audio frame sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package audio_pkg;

    localparam int CTRL_W          = 4;   // effects control word width
    localparam int CTRL_FEEDBACK   = 1;   // control bit index of FEEDBACK
    localparam int FRAME_CNT_W     = 16;  // completed-frame counter width
    localparam int DEF_CLK_DIV     = 4;
    localparam int DEF_SAMPLE_BITS = 16;
    localparam int DEF_SLOT_BITS   = 32;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        START    = 2'd1,
        RUN      = 2'd2,
        STOPPING = 2'd3
    } seq_state_t;

    // Counter width that stays at least one bit for a modulus of 1
    function automatic int cnt_width(input int modulus);
        return (modulus > 1) ? $clog2(modulus) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/audio_frame_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : audio_frame_sequencer_if
// Description : Host control handshake plus codec/effects timing outputs.
//               master = sequencer side, slave = host/effects side.
// Revision    : 1.0 - initial release
// ============================================================================
interface audio_frame_sequencer_if;
    import audio_pkg::*;

    logic                   enable;
    logic [CTRL_W-1:0]      ctrl_wdata;
    logic                   ctrl_valid;
    logic                   ctrl_ready;
    logic [CTRL_W-1:0]      control;
    logic                   bclk;
    logic                   lrck;
    logic                   sample_req;
    logic                   sample_end;
    logic                   chan;
    logic                   running;
    logic [FRAME_CNT_W-1:0] frame_cnt;

    modport master (
        input  enable, ctrl_wdata, ctrl_valid,
        output ctrl_ready, control, bclk, lrck, sample_req, sample_end,
               chan, running, frame_cnt
    );

    modport slave (
        output enable, ctrl_wdata, ctrl_valid,
        input  ctrl_ready, control, bclk, lrck, sample_req, sample_end,
               chan, running, frame_cnt
    );

endinterface
`default_nettype wire

// File: rtl/audio_frame_sequencer_bclk_gen.sv
`default_nettype none
// ============================================================================
// Module      : audio_bclk_gen
// Description : Bit-clock divider and frame bit counter. A bit tick is the
//               cycle whose edge takes bclk 1->0; wrap flags the tick that
//               returns bit_cnt to 0.
// Revision    : 1.0 - initial release
// ============================================================================
module audio_bclk_gen
    import audio_pkg::*;
#(
    parameter int CLK_DIV   = DEF_CLK_DIV,
    parameter int SLOT_BITS = DEF_SLOT_BITS,
    parameter int BIT_W     = $clog2(2*DEF_SLOT_BITS)
) (
    input  wire logic             clk,
    input  wire logic             reset_n,
    input  wire logic             i_run,
    input  wire logic             i_clr,
    output logic                  o_bclk,
    output logic [BIT_W-1:0]      o_bit_cnt,
    output logic                  o_bit_tick,
    output logic                  o_wrap
);

    localparam int                DIV_W      = cnt_width(CLK_DIV);
    localparam logic [DIV_W-1:0]  C_DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0]  C_BIT_LAST = BIT_W'(2*SLOT_BITS - 1);

    logic [DIV_W-1:0] r_div_cnt;
    logic             r_bclk;
    logic [BIT_W-1:0] r_bit_cnt;
    logic             w_div_wrap;
    logic             w_bit_tick;
    logic             w_wrap;

    assign w_div_wrap = i_run & (r_div_cnt == C_DIV_LAST);
    assign w_bit_tick = w_div_wrap & r_bclk;
    assign w_wrap     = w_bit_tick & (r_bit_cnt == C_BIT_LAST);

    // Divider, bclk toggle and bit counter advance
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_div_cnt <= '0;
            r_bclk    <= 1'b0;
            r_bit_cnt <= '0;
        end else if (i_clr) begin
            r_div_cnt <= '0;
            r_bclk    <= 1'b0;
            r_bit_cnt <= '0;
        end else if (i_run) begin
            r_div_cnt <= w_div_wrap ? '0 : r_div_cnt + DIV_W'(1);
            if (w_div_wrap) begin
                r_bclk <= ~r_bclk;
            end
            if (w_bit_tick) begin
                r_bit_cnt <= w_wrap ? '0 : r_bit_cnt + BIT_W'(1);
            end
        end
    end

    assign o_bclk     = r_bclk;
    assign o_bit_cnt  = r_bit_cnt;
    assign o_bit_tick = w_bit_tick;
    assign o_wrap     = w_wrap;

endmodule
`default_nettype wire

// File: rtl/audio_frame_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : audio_frame_sequencer
// Description : Codec timing master (bclk/lrck) with per-slot sample strobes
//               and frame-aligned application of the effects control word.
// Revision    : 1.0 - initial release
// ============================================================================
module audio_frame_sequencer
    import audio_pkg::*;
#(
    parameter int CLK_DIV     = DEF_CLK_DIV,
    parameter int SAMPLE_BITS = DEF_SAMPLE_BITS,
    parameter int SLOT_BITS   = DEF_SLOT_BITS
) (
    input  wire logic               clk,
    input  wire logic               reset_n,
    audio_frame_sequencer_if.master bus
);

    localparam int               BIT_W   = $clog2(2*SLOT_BITS);
    localparam logic [BIT_W-1:0] C_SLOT  = BIT_W'(SLOT_BITS);
    // sample_end lands one bit after the word because of the I2S delay bit
    localparam logic [BIT_W-1:0] C_END_L = BIT_W'(SAMPLE_BITS + 1);
    localparam logic [BIT_W-1:0] C_END_R = BIT_W'(SLOT_BITS + SAMPLE_BITS + 1);

    seq_state_t             r_state;
    seq_state_t             w_state_nxt;
    logic                   w_run;
    logic                   w_clr;
    logic                   w_stop_now;
    logic                   w_bclk;
    logic [BIT_W-1:0]       w_bit_cnt;
    logic [BIT_W-1:0]       w_bit_nxt;
    logic                   w_bit_tick;
    logic                   w_wrap;
    logic                   w_left_req;
    logic                   w_right_req;
    logic                   w_end_pulse;
    logic                   w_accept;
    logic                   w_apply;

    logic                   r_lrck;
    logic                   r_sample_req;
    logic                   r_sample_end;
    logic [FRAME_CNT_W-1:0] r_frame_cnt;
    logic [CTRL_W-1:0]      r_control;
    logic [CTRL_W-1:0]      r_staged;
    logic                   r_pending;

    assign w_run = (r_state == RUN) || (r_state == STOPPING);
    assign w_clr = (r_state == START);

    audio_bclk_gen #(
        .CLK_DIV   (CLK_DIV),
        .SLOT_BITS (SLOT_BITS),
        .BIT_W     (BIT_W)
    ) u_bclk_gen (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_run      (w_run),
        .i_clr      (w_clr),
        .o_bclk     (w_bclk),
        .o_bit_cnt  (w_bit_cnt),
        .o_bit_tick (w_bit_tick),
        .o_wrap     (w_wrap)
    );

    // Sequencer state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; STOPPING ends on the frame wrap unless re-enabled
    always_comb begin
        w_state_nxt = r_state;
        w_stop_now  = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.enable) begin
                    w_state_nxt = START;
                end
            end
            START: begin
                w_state_nxt = RUN;
            end
            RUN: begin
                if (!bus.enable) begin
                    w_state_nxt = STOPPING;
                end
            end
            STOPPING: begin
                if (bus.enable) begin
                    w_state_nxt = RUN;
                end else if (w_wrap) begin
                    w_state_nxt = IDLE;
                    w_stop_now  = 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Strobe decode on the bit_cnt value about to be entered
    assign w_bit_nxt   = w_wrap ? '0 : w_bit_cnt + BIT_W'(1);
    assign w_left_req  = w_clr | (w_wrap & ~w_stop_now);
    assign w_right_req = w_bit_tick & (w_bit_nxt == C_SLOT);
    assign w_end_pulse = w_bit_tick &
                         ((w_bit_nxt == C_END_L) || (w_bit_nxt == C_END_R));

    // Registered lrck, sample strobes and frame counter
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_lrck       <= 1'b0;
            r_sample_req <= 1'b0;
            r_sample_end <= 1'b0;
            r_frame_cnt  <= '0;
        end else begin
            r_sample_req <= w_left_req | w_right_req;
            r_sample_end <= w_end_pulse;
            if (w_clr) begin
                r_lrck <= 1'b0;
            end else if (w_bit_tick) begin
                r_lrck <= (w_bit_nxt >= C_SLOT);
            end
            if (w_wrap) begin
                r_frame_cnt <= r_frame_cnt + FRAME_CNT_W'(1);
            end
        end
    end

    // A staged word is applied at a left-slot boundary, or at once when idle.
    // Accept and apply are exclusive since accept requires an empty slot.
    assign w_accept = bus.ctrl_valid & ~r_pending;
    assign w_apply  = r_pending & (w_left_req | (r_state == IDLE));

    // Control word staging and frame-aligned update
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_control <= '0;
            r_staged  <= '0;
            r_pending <= 1'b0;
        end else if (w_accept) begin
            r_staged  <= bus.ctrl_wdata;
            r_pending <= 1'b1;
        end else if (w_apply) begin
            r_control <= r_staged;
            r_pending <= 1'b0;
        end
    end

    assign bus.ctrl_ready = ~r_pending;
    assign bus.control    = r_control;
    assign bus.bclk       = w_bclk;
    assign bus.lrck       = r_lrck;
    assign bus.chan       = r_lrck;
    assign bus.sample_req = r_sample_req;
    assign bus.sample_end = r_sample_end;
    assign bus.running    = w_run;
    assign bus.frame_cnt  = r_frame_cnt;

endmodule
`default_nettype wire
